up_sampler: RTL

- Consumer end of the Gaussian stage output FIFO: drives the FIFO read enable and takes its data/valid/empty outputs.
- Performs 2x nearest-neighbour upsampling for the next octave. Each input pixel is replicated horizontally, and each input row is replayed from a line buffer.
- Emits a ready/valid pixel stream with line/frame markers toward the DoG/octave logic.

---
 rtl/up_sampler.sv | 127 ++++++++++++
 1 files changed

// File: rtl/up_sampler.sv
// 2x nearest-neighbour upsampler: pulls pixels from the Gaussian-stage FIFO,
// emits each pixel twice and replays every row from a line buffer.
module up_sampler #(
    parameter int PIX_W     = 8,
    parameter int IN_WIDTH  = 320,
    parameter int IN_HEIGHT = 240,
    parameter int COL_W     = 9,
    parameter int ROW_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [PIX_W-1:0] fifo_dout,
    input  logic             fifo_valid,
    output logic             rd_en_up,
    output logic [PIX_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_line_last,
    output logic             out_frame_last,
    output logic             err_overrun
);

    typedef enum logic {
        FETCH  = 1'b0,
        REPLAY = 1'b1
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IN_HEIGHT - 1);

    state_t           r_state, w_state_nxt;
    logic [COL_W-1:0] r_col, w_col_nxt;
    logic [ROW_W-1:0] r_row, w_row_nxt;
    logic             r_phase, w_phase_nxt;
    logic             r_hold_full;
    logic             r_rd_pend;
    logic             r_err;
    logic [PIX_W-1:0] r_hold;
    logic [PIX_W-1:0] r_rd_data;
    logic [PIX_W-1:0] r_linebuf [IN_WIDTH];

    logic w_valid, w_hs, w_accept, w_col_last, w_row_last;

    always_comb begin
        w_valid    = (r_state == REPLAY) | r_hold_full;
        w_hs       = w_valid & out_ready;
        w_accept   = fifo_valid & r_rd_pend;
        w_col_last = (r_col == LAST_COL);
        w_row_last = (r_row == LAST_ROW);

        // rst gates the request so it is low for the whole reset pulse
        rd_en_up       = !rst & (r_state == FETCH) & !fifo_empty & !r_hold_full & !r_rd_pend;
        out_valid      = w_valid;
        out_data       = (r_state == REPLAY) ? r_rd_data : r_hold;
        out_line_last  = w_valid & r_phase & w_col_last;
        out_frame_last = out_line_last & (r_state == REPLAY) & w_row_last;
        err_overrun    = r_err;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_phase_nxt = r_phase;
        if (w_hs) begin
            w_phase_nxt = ~r_phase;
            if (r_phase) begin
                if (w_col_last) begin
                    w_col_nxt = '0;
                    if (r_state == REPLAY) begin
                        w_state_nxt = FETCH;
                        w_row_nxt   = w_row_last ? '0 : r_row + 1'b1;
                    end else begin
                        w_state_nxt = REPLAY;
                    end
                end else begin
                    w_col_nxt = r_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FETCH;
            r_col       <= '0;
            r_row       <= '0;
            r_phase     <= 1'b0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_phase <= w_phase_nxt;

            if (w_accept) begin
                r_hold      <= fifo_dout;
                r_hold_full <= 1'b1;
            end else if (w_hs && r_phase && r_state == FETCH) begin
                r_hold_full <= 1'b0;
            end

            if (rd_en_up) begin
                r_rd_pend <= 1'b1;
            end else if (fifo_valid) begin
                r_rd_pend <= 1'b0;
            end

            if (fifo_valid && !r_rd_pend) begin
                r_err <= 1'b1;
            end
        end
    end

    // Prefetch tracks the next column so REPLAY output has no read bubble
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_linebuf[r_col] <= fifo_dout;
        end
        r_rd_data <= r_linebuf[w_col_nxt];
    end

endmodule
